// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg
// Shared definitions for the paced FIFO reader: FSM state encoding, default
// pacing parameters and the wrapping word-counter increment helper. The board
// top, the reader and the bench all import this so they agree on the values.
package fifo_drain_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } drain_state_e;

    // Default pop period: one word per second at a 50 MHz board clock.
    localparam int unsigned DEFAULT_TICK = 32'd50_000_000;
    localparam int unsigned DEFAULT_CW   = 32'd26;
    localparam int unsigned COUNT_W      = 32'd8;

    // Word counter increment; wraps 255 -> 0 naturally through truncation.
    function automatic logic [COUNT_W-1:0] count_inc(input logic [COUNT_W-1:0] c);
        return c + {{(COUNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/fifo_drain_tick_gen.sv
// tick_gen
// Prescaler producing a registered one-cycle tick every TICK clocks.
// After clr is released the first tick appears TICK cycles later, and then
// every TICK cycles.
// Ports:
//   clk   - clock
//   reset - synchronous active-low reset
//   clr   - synchronous clear of prescaler and tick
//   tick  - one-cycle pulse, registered
module tick_gen
    import fifo_drain_pkg::*;
#(
    parameter int unsigned TICK = DEFAULT_TICK,
    parameter int unsigned CW   = DEFAULT_CW
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam logic [CW-1:0] LAST = CW'(TICK - 32'd1);

    logic [CW-1:0] cnt_r;
    logic          tick_r;

    // Prescaler count and registered tick (tick lags the terminal count by one).
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b0;
        end else if (clr) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b0;
        end else begin
            tick_r <= (cnt_r == LAST);
            if (cnt_r == LAST) begin
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/fifo_drain.sv
// fifo_drain
// Paced read engine for a first-word-fall-through FIFO. After start it pops
// one word every TICK cycles, holds it on data_out and counts it; it stops on
// stop or when a tick finds the FIFO empty.
// Ports:
//   clk, reset      - clock, synchronous active-low reset
//   start, stop     - one-cycle command pulses (stop dominates)
//   empty, data_in  - FIFO status and head word
//   rd              - pop strobe (combinational, aligned with data_in sampling)
//   data_out, valid - last popped word and its qualifier (registered)
//   count           - words popped since start, 8-bit wrapping (registered)
//   busy            - engine is running (registered)
//   drained         - last run ended on an empty FIFO (registered)
module fifo_drain
    import fifo_drain_pkg::*;
#(
    parameter int unsigned B    = 32'd3,
    parameter int unsigned TICK = DEFAULT_TICK,
    parameter int unsigned CW   = DEFAULT_CW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               empty,
    input  logic [B-1:0]       data_in,
    output logic               rd,
    output logic [B-1:0]       data_out,
    output logic               valid,
    output logic [COUNT_W-1:0] count,
    output logic               busy,
    output logic               drained
);

    drain_state_e       state_r;
    drain_state_e       state_nxt_s;
    logic               tick_s;
    logic               clr_s;
    logic               start_run_s;
    logic               empty_tick_s;
    logic               rd_s;
    logic [B-1:0]       data_out_r;
    logic               valid_r;
    logic [COUNT_W-1:0] count_r;
    logic               busy_r;
    logic               drained_r;

    // Prescaler is held clear in IDLE, so it restarts from zero on entry to RUN.
    assign clr_s = (state_r == IDLE);

    tick_gen #(
        .TICK (TICK),
        .CW   (CW)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_s),
        .tick  (tick_s)
    );

    assign start_run_s  = (state_r == IDLE) && start && !stop;
    // A stop on the tick cycle wins over both the pop and the empty exit.
    assign empty_tick_s = (state_r == RUN) && tick_s && empty && !stop;
    // Gated by reset so a mid-run reset never pops the FIFO.
    assign rd_s         = reset && (state_r == RUN) && tick_s && !empty && !stop;

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_run_s) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (stop || empty_tick_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register and registered busy flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == RUN);
        end
    end

    // Output word, counter and drained flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_out_r <= {B{1'b0}};
            valid_r    <= 1'b0;
            count_r    <= {COUNT_W{1'b0}};
            drained_r  <= 1'b0;
        end else begin
            if (start_run_s) begin
                count_r   <= {COUNT_W{1'b0}};
                drained_r <= 1'b0;
            end else if (rd_s) begin
                data_out_r <= data_in;
                valid_r    <= 1'b1;
                count_r    <= count_inc(count_r);
            end else if (empty_tick_s) begin
                drained_r <= 1'b1;
            end
        end
    end

    assign rd       = rd_s;
    assign data_out = data_out_r;
    assign valid    = valid_r;
    assign count    = count_r;
    assign busy     = busy_r;
    assign drained  = drained_r;

endmodule

// File: tb/tb_fifo_drain.sv
module tb_fifo_drain;
    import fifo_drain_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // DUT 1: TICK=4
    logic       start1, stop1, wr1;
    logic [2:0] wdata1;
    logic       rd1, valid1, busy1, drained1, empty1;
    logic [2:0] data_in1, data_out1;
    logic [7:0] count1;
    logic [2:0] mem1 [4];
    logic [2:0] wp1, rp1, lvl1;

    // DUT 2: TICK=2 (wrap test)
    logic       start2, stop2, wr2;
    logic [2:0] wdata2;
    logic       rd2, valid2, busy2, drained2, empty2;
    logic [2:0] data_in2, data_out2;
    logic [7:0] count2;
    logic [2:0] mem2 [4];
    logic [2:0] wp2, rp2, lvl2;

    int n_cmp = 0;
    int n_err = 0;
    int rd_tot1 = 0;
    int rd_tot2 = 0;
    int vio = 0;
    logic rd1_prev = 1'b0;
    logic rd2_prev = 1'b0;
    int base;
    int wi;
    int guard;

    fifo_drain #(.B(3), .TICK(4), .CW(3)) dut1 (
        .clk(clk), .reset(rst_n), .start(start1), .stop(stop1),
        .empty(empty1), .data_in(data_in1), .rd(rd1), .data_out(data_out1),
        .valid(valid1), .count(count1), .busy(busy1), .drained(drained1)
    );

    fifo_drain #(.B(3), .TICK(2), .CW(2)) dut2 (
        .clk(clk), .reset(rst_n), .start(start2), .stop(stop2),
        .empty(empty2), .data_in(data_in2), .rd(rd2), .data_out(data_out2),
        .valid(valid2), .count(count2), .busy(busy2), .drained(drained2)
    );

    // cola_fifo W=2 models (4 words, first-word-fall-through). Not reset by
    // rst_n after power-up so contents survive a mid-run reader reset.
    logic f_init;
    assign lvl1     = wp1 - rp1;
    assign empty1   = (wp1 == rp1);
    assign data_in1 = mem1[rp1[1:0]];
    assign lvl2     = wp2 - rp2;
    assign empty2   = (wp2 == rp2);
    assign data_in2 = mem2[rp2[1:0]];

    always @(posedge clk) begin
        if (f_init) begin
            wp1 <= 3'd0; rp1 <= 3'd0; wp2 <= 3'd0; rp2 <= 3'd0;
        end else begin
            if (wr1 && (lvl1 != 3'd4)) begin
                mem1[wp1[1:0]] <= wdata1;
                wp1 <= wp1 + 3'd1;
            end
            if (rd1 && !empty1) rp1 <= rp1 + 3'd1;
            if (wr2 && (lvl2 != 3'd4)) begin
                mem2[wp2[1:0]] <= wdata2;
                wp2 <= wp2 + 3'd1;
            end
            if (rd2 && !empty2) rp2 <= rp2 + 3'd1;
        end
    end

    // Pop counters and invariant monitor, sampled on pre-edge values.
    always @(posedge clk) begin
        if (rd1) rd_tot1 = rd_tot1 + 1;
        if (rd2) rd_tot2 = rd_tot2 + 1;
        if (rd1 && (empty1 || rd1_prev || !busy1 || !rst_n)) vio = vio + 1;
        if (rd2 && (empty2 || rd2_prev || !busy2 || !rst_n)) vio = vio + 1;
        rd1_prev = rd1;
        rd2_prev = rd2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push1(input logic [2:0] v);
        wr1 = 1'b1; wdata1 = v;
        @(negedge clk);
        wr1 = 1'b0;
    endtask

    // Called at the negedge of cycle 0; returns at the negedge of cycle 1.
    task automatic pulse_start1();
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    task automatic feed2(input int limit);
        while (wi < limit && guard < 3000) begin
            if (lvl2 < 3'd4) begin
                wr2 = 1'b1; wdata2 = wi[2:0]; wi++;
            end else begin
                wr2 = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        wr2 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; f_init = 1'b1;
        start1 = 1'b1; stop1 = 1'b1; wr1 = 1'b0; wdata1 = 3'd0;
        start2 = 1'b1; stop2 = 1'b0; wr2 = 1'b0; wdata2 = 3'd0;
        wi = 0; guard = 0;

        // Reset held 3 cycles with arbitrary inputs.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            f_init = 1'b0;
            chk("reset_rd", {31'd0, rd1}, 32'd0);
        end
        chk("reset_data_out", {29'd0, data_out1}, 32'd0);
        chk("reset_valid", {31'd0, valid1}, 32'd0);
        chk("reset_count", {24'd0, count1}, 32'd0);
        chk("reset_busy", {31'd0, busy1}, 32'd0);
        chk("reset_drained", {31'd0, drained1}, 32'd0);
        chk("reset_busy2", {31'd0, busy2}, 32'd0);
        rst_n = 1'b1; start1 = 1'b0; stop1 = 1'b0; start2 = 1'b0;
        @(negedge clk);

        // Normal drain: 5, 2, 7.
        push1(3'd5); push1(3'd2); push1(3'd7);
        base = rd_tot1;
        pulse_start1();
        chk("drain_busy_rise", {31'd0, busy1}, 32'd1);
        step(3);
        chk("drain_no_early_rd", {31'd0, rd1}, 32'd0);
        step(1);
        chk("drain_rd_c5", {31'd0, rd1}, 32'd1);
        step(1);
        chk("drain_word1", {29'd0, data_out1}, 32'd5);
        chk("drain_count1", {24'd0, count1}, 32'd1);
        chk("drain_valid1", {31'd0, valid1}, 32'd1);
        step(3);
        chk("drain_rd_c9", {31'd0, rd1}, 32'd1);
        step(1);
        chk("drain_word2", {29'd0, data_out1}, 32'd2);
        step(3);
        chk("drain_rd_c13", {31'd0, rd1}, 32'd1);
        step(1);
        chk("drain_word3", {29'd0, data_out1}, 32'd7);
        chk("drain_count3", {24'd0, count1}, 32'd3);
        step(3);
        chk("drain_empty_tick_busy", {31'd0, busy1}, 32'd1);
        step(1);
        chk("drain_busy_fall", {31'd0, busy1}, 32'd0);
        chk("drain_drained", {31'd0, drained1}, 32'd1);
        chk("drain_valid_hold", {31'd0, valid1}, 32'd1);
        chk("drain_data_hold", {29'd0, data_out1}, 32'd7);
        chk("drain_rd_total", rd_tot1 - base, 32'd3);

        // Start on empty FIFO.
        @(negedge clk);
        base = rd_tot1;
        pulse_start1();
        chk("empty_busy", {31'd0, busy1}, 32'd1);
        chk("empty_drained_clr", {31'd0, drained1}, 32'd0);
        chk("empty_count_clr", {24'd0, count1}, 32'd0);
        step(5);
        chk("empty_busy_fall", {31'd0, busy1}, 32'd0);
        chk("empty_drained", {31'd0, drained1}, 32'd1);
        chk("empty_count", {24'd0, count1}, 32'd0);
        chk("empty_no_rd", rd_tot1 - base, 32'd0);

        // Stop exactly on the second tick.
        push1(3'd1); push1(3'd3); push1(3'd4); push1(3'd6);
        base = rd_tot1;
        pulse_start1();
        step(4);
        chk("stop_rd_first", {31'd0, rd1}, 32'd1);
        step(4);
        stop1 = 1'b1;
        #1;
        chk("stop_suppresses_rd", {31'd0, rd1}, 32'd0);
        step(1);
        stop1 = 1'b0;
        chk("stop_busy", {31'd0, busy1}, 32'd0);
        chk("stop_count", {24'd0, count1}, 32'd1);
        chk("stop_drained", {31'd0, drained1}, 32'd0);
        chk("stop_data", {29'd0, data_out1}, 32'd1);
        chk("stop_fifo_level", {29'd0, lvl1}, 32'd3);
        chk("stop_rd_total", rd_tot1 - base, 32'd1);

        // Mid-run reset at cycle 6.
        base = rd_tot1;
        pulse_start1();
        step(4);
        chk("mrst_rd_c5", {31'd0, rd1}, 32'd1);
        step(1);
        chk("mrst_data", {29'd0, data_out1}, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("mrst_rd_gated", {31'd0, rd1}, 32'd0);
        step(1);
        rst_n = 1'b1;
        chk("mrst_busy", {31'd0, busy1}, 32'd0);
        chk("mrst_count", {24'd0, count1}, 32'd0);
        chk("mrst_valid", {31'd0, valid1}, 32'd0);
        chk("mrst_data_clr", {29'd0, data_out1}, 32'd0);
        chk("mrst_drained", {31'd0, drained1}, 32'd0);
        step(8);
        chk("mrst_fifo_level", {29'd0, lvl1}, 32'd2);
        chk("mrst_rd_total", rd_tot1 - base, 32'd1);

        // start + stop together in IDLE.
        base = rd_tot1;
        start1 = 1'b1; stop1 = 1'b1;
        step(1);
        start1 = 1'b0; stop1 = 1'b0;
        chk("coll_busy", {31'd0, busy1}, 32'd0);
        step(6);
        chk("coll_busy_later", {31'd0, busy1}, 32'd0);
        chk("coll_no_rd", rd_tot1 - base, 32'd0);

        // Wrap: 256 words, writer racing a TICK=2 reader.
        feed2(4);
        start2 = 1'b1;
        step(1);
        start2 = 1'b0;
        chk("wrap_busy", {31'd0, busy2}, 32'd1);
        feed2(256);
        chk("wrap_fed", wi, 32'd256);
        step(20);
        chk("wrap_rd_total", rd_tot2, 32'd256);
        chk("wrap_count", {24'd0, count2}, 32'd0);
        chk("wrap_drained", {31'd0, drained2}, 32'd1);
        chk("wrap_busy_fall", {31'd0, busy2}, 32'd0);
        chk("wrap_last_word", {29'd0, data_out2}, 32'd7);

        chk("rd_invariants", vio, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
